lcd_master_channel_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one Avalon-ST byte stream between NUM_IN requesters on the LCD master path. It sits upstream of the channel-to-packet adapter stage. It locks a grant for the full length of a packet and tags every forwarded beat with the requester index on `out_channel`. It drives one registered output stage, so throughput is one beat per cycle while a packet is locked.

---
 rtl/lcd_master_pkg.sv | 35 +++
 rtl/lcd_master_rr_picker.sv | 21 ++
 rtl/lcd_master_channel_arbiter.sv | 137 +++++++++++++
 tb/tb_lcd_master_channel_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_master_pkg.sv
// Shared types and the round-robin selection helper for the LCD master channel arbiter.
package lcd_master_pkg;

  localparam int MAX_IN = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Walks offsets from the highest down so the lowest offset from ptr wins last.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] req,
                                    input logic [IDX_W-1:0]  ptr,
                                    input logic [IDX_W:0]    n);
    pick_t            res;
    logic [IDX_W:0]   pos;
    res = '0;
    for (int k = MAX_IN - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= n) pos = pos - n;
      if (((IDX_W+1)'(k) < n) && req[pos[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lcd_master_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr_i, wrapping.
module lcd_master_rr_picker
  import lcd_master_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_IN'(req_i), ptr_i, (IDX_W+1)'(NUM_IN));
    found_o = pick.found;
    idx_o   = pick.idx;
  end

endmodule

// File: rtl/lcd_master_channel_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_IN Avalon-ST byte streams into one
// registered output stream tagged with the source index on out_channel.
module lcd_master_channel_arbiter
  import lcd_master_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 8,
  parameter int CHAN_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHAN_W-1:0]        out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [NUM_IN-1:0]        grant,
  output logic                     busy
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic                ov_q, ov_d;
  logic [DATA_W-1:0]   od_q, od_d;
  logic [CHAN_W-1:0]   och_q, och_d;
  logic                osop_q, osop_d;
  logic                oeop_q, oeop_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_IN-1:0]   pick_onehot;
  logic                out_free;
  logic                accept;
  logic                sel_sop, sel_eop;
  logic [DATA_W-1:0]   sel_data;

  lcd_master_rr_picker #(.NUM_IN(NUM_IN)) u_picker (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // grant_q is all-zero in IDLE, so it alone gates in_ready and the beat mux.
  assign out_free = !ov_q || out_ready;
  assign in_ready = grant_q & {NUM_IN{out_free}};
  assign accept   = |(in_valid & in_ready);
  assign sel_sop  = |(in_startofpacket & grant_q);
  assign sel_eop  = |(in_endofpacket & grant_q);

  always_comb begin
    sel_data    = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q[i]) sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
      pick_onehot[i] = (pick_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    ov_d    = ov_q;
    od_d    = od_q;
    och_d   = och_q;
    osop_d  = osop_q;
    oeop_d  = oeop_q;
    if (out_ready) ov_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          gidx_d  = pick_idx;
          grant_d = pick_onehot;
        end
      end
      LOCKED: begin
        if (accept) begin
          ov_d   = 1'b1;
          od_d   = sel_data;
          och_d  = CHAN_W'(gidx_q);
          osop_d = sel_sop;
          oeop_d = sel_eop;
          if (sel_eop) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (gidx_q == IDX_W'(NUM_IN - 1)) ? '0 : gidx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      och_q   <= '0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      och_q   <= och_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
    end
  end

  assign out_valid         = ov_q;
  assign out_data          = od_q;
  assign out_channel       = och_q;
  assign out_startofpacket = osop_q;
  assign out_endofpacket   = oeop_q;
  assign grant             = grant_q;
  assign busy              = (state_q == LOCKED);

endmodule

// File: tb/tb_lcd_master_channel_arbiter.sv
// Scoreboard bench: directed packets push expected beats; a negedge monitor pops and compares.
module tb_lcd_master_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid, in_ready, in_sop, in_eop;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid, out_startofpacket, out_endofpacket, busy;
  logic [7:0]  out_data, out_channel;
  logic [3:0]  grant;

  logic        sv[4];
  logic [7:0]  sd[4];
  logic        ss[4];
  logic        se[4];

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t exp_q[$];
  beat_t e_m;
  int    beat_cyc[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_master_channel_arbiter #(.NUM_IN(4), .DATA_W(8), .CHAN_W(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .grant             (grant),
    .busy              (busy)
  );

  always_comb begin
    in_valid = '0;
    in_data  = '0;
    in_sop   = '0;
    in_eop   = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]        = sv[i];
      in_data[i*8 +: 8]  = sd[i];
      in_sop[i]          = ss[i];
      in_eop[i]          = se[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_extra actual ch=%0d d=%0h required none", out_channel, out_data);
      end else begin
        e_m = exp_q.pop_front();
        chk("beat", 32'({out_channel, out_data, out_startofpacket, out_endofpacket}), 32'(e_m));
        beat_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_pkt(input logic [7:0] ch, input logic [7:0] base, input int n, input int len);
    for (int b = 0; b < n; b++)
      exp_q.push_back('{ch: ch, d: base + 8'(b), sop: (b == 0), eop: (b == len - 1)});
  endtask

  // Drives nbeats of a len-beat packet; optionally idles 2 cycles after beat gap_after.
  task automatic send_pkt(input int r, input logic [7:0] base, input int len,
                          input int nbeats, input int gap_after);
    bit ok;
    for (int b = 0; b < nbeats; b++) begin
      sv[r] = 1'b1;
      sd[r] = base + 8'(b);
      ss[r] = (b == 0);
      se[r] = (b == len - 1);
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk);
        if (in_ready[r]) ok = 1'b1;
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL accept_timeout req=%0d beat=%0d", r, b);
        sv[r] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      sv[r] = 1'b0;
      if (b == gap_after) begin
        repeat (2) begin
          @(negedge clk);
          chk("grant_hold", 32'(grant), 32'(1) << r);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0; sd[i] = '0; ss[i] = 1'b0; se[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_channel", 32'(out_channel), 0);
    chk("rst_sop_eop", 32'({out_startofpacket, out_endofpacket}), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // single requester, 4 beats
    push_pkt(8'd1, 8'h11, 4, 4);
    fork
      send_pkt(1, 8'h11, 4, 4, -1);
      begin
        @(negedge clk);
        chk("grant_before_arb", 32'(grant), 0);
        @(negedge clk);
        chk("grant_after_arb", 32'(grant), 32'b0010);
        chk("ready_after_arb", 32'(in_ready), 32'b0010);
        chk("busy_locked", 32'(busy), 1);
      end
    join
    wait_drain();

    // contention between 0 and 1 from reset
    do_reset();
    push_pkt(8'd0, 8'hA0, 2, 2);
    push_pkt(8'd1, 8'hB0, 2, 2);
    push_pkt(8'd0, 8'hA2, 2, 2);
    push_pkt(8'd1, 8'hB2, 2, 2);
    beat_cyc.delete();
    fork
      begin send_pkt(0, 8'hA0, 2, 2, -1); send_pkt(0, 8'hA2, 2, 2, -1); end
      begin send_pkt(1, 8'hB0, 2, 2, -1); send_pkt(1, 8'hB2, 2, 2, -1); end
    join
    wait_drain();
    chk("in_pkt_spacing", 32'(beat_cyc[1] - beat_cyc[0]), 1);
    chk("bubble_0to1", 32'(beat_cyc[2] - beat_cyc[1]), 2);
    chk("bubble_1to0", 32'(beat_cyc[4] - beat_cyc[3]), 2);

    // backpressure for 3 cycles mid-packet
    push_pkt(8'd2, 8'h31, 4, 4);
    fork
      send_pkt(2, 8'h31, 4, 4, -1);
      begin
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (out_valid && out_data == 8'h32) seen = 1'b1;
        end
        chk("stall_sync", 32'(seen), 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_data", 32'(out_data), 32'h33);
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_in_ready", 32'(in_ready), 0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // granted requester 3 drops valid mid-packet while requester 0 waits
    push_pkt(8'd3, 8'h41, 4, 4);
    push_pkt(8'd0, 8'h01, 2, 2);
    fork
      send_pkt(3, 8'h41, 4, 4, 1);
      send_pkt(0, 8'h01, 2, 2, -1);
    join
    wait_drain();

    // reset after beat 2 of a 5-beat packet
    push_pkt(8'd1, 8'h51, 2, 5);
    send_pkt(1, 8'h51, 5, 2, -1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("busy_before_rst", 32'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_channel", 32'(out_channel), 0);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    push_pkt(8'd0, 8'h61, 2, 2);
    push_pkt(8'd2, 8'h71, 2, 2);
    fork
      send_pkt(0, 8'h61, 2, 2, -1);
      send_pkt(2, 8'h71, 2, 2, -1);
    join
    wait_drain();

    // single-beat packets, all four valid, wrap-around
    do_reset();
    push_pkt(8'd0, 8'h80, 1, 1);
    push_pkt(8'd1, 8'h81, 1, 1);
    push_pkt(8'd2, 8'h82, 1, 1);
    push_pkt(8'd3, 8'h83, 1, 1);
    push_pkt(8'd0, 8'h84, 1, 1);
    fork
      begin send_pkt(0, 8'h80, 1, 1, -1); send_pkt(0, 8'h84, 1, 1, -1); end
      send_pkt(1, 8'h81, 1, 1, -1);
      send_pkt(2, 8'h82, 1, 1, -1);
      send_pkt(3, 8'h83, 1, 1, -1);
    join
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
